jtsdram_vtimer: RTL and testbench
=================================

JTSDRAM_VTIMER -- requirements
Module: jtsdram_vtimer

Interface
REQ-001 Parameter HTOTAL, 384: pixels per line, count range 0..HTOTAL-1.
REQ-002 Parameter HACTIVE, 256: visible pixels per line, starting at hdump=0.
REQ-003 Parameter HS_START, 288: first hdump with HS high.
REQ-004 Parameter HS_LEN, 32: HS width in pixels.
REQ-005 Parameter VTOTAL, 264: lines per frame, count range 0..VTOTAL-1.
REQ-006 Parameter VACTIVE, 224: visible lines per frame, starting at vdump=0.
REQ-007 Parameter VS_START, 240: first vdump with VS high.
REQ-008 Parameter VS_LEN, 3: VS width in lines.
REQ-009 clk  input  1  single system clock; all state changes on its rising edge.
REQ-010 rst  input  1  reset, asynchronous and active-high.
REQ-011 pxl_cen  input  1  pixel clock enable; counters advance only on clk edges with pxl_cen=1.
REQ-012 hdump  output  9  horizontal pixel counter.
REQ-013 vdump  output  9  vertical line counter.
REQ-014 LHBL  output  1  high while the pixel is horizontally visible.
REQ-015 LVBL  output  1  high while the line is vertically visible.
REQ-016 HS  output  1  horizontal sync, active-high.
REQ-017 VS  output  1  vertical sync, active-high.
REQ-018 frame  output  1  toggles once per frame.

Function
REQ-019 All outputs SHALL be registered; with pxl_cen=0, every output SHALL hold its value.
REQ-020 On a pxl_cen cycle, hdump SHALL increment by 1; at HTOTAL-1 it SHALL wrap to 0.
REQ-021 vdump SHALL increment by 1 only on the pxl_cen cycle where hdump wraps; at VTOTAL-1 it SHALL wrap to 0 in that same cycle (simultaneous h and v wrap).
REQ-022 LHBL SHALL equal (hdump < HACTIVE), evaluated on the new hdump value in the same register update (zero latency relative to hdump).
REQ-023 LVBL SHALL equal (vdump < VACTIVE), evaluated on the new vdump value; LVBL therefore changes only at hdump=0.
REQ-024 HS SHALL be high iff HS_START <= hdump < HS_START+HS_LEN, same timing as LHBL.
REQ-025 VS SHALL be high iff VS_START <= vdump < VS_START+VS_LEN, same timing as LVBL; it changes only at hdump=0.
REQ-026 frame SHALL invert on the pxl_cen cycle where vdump wraps to 0.
REQ-027 Counter arithmetic SHALL be 9-bit unsigned; the parameters satisfy HACTIVE < HTOTAL <= 512, VACTIVE < VTOTAL <= 512, and each sync window lies inside blanking; other values are unsupported.
REQ-028 With pxl_cen held at 1, one line SHALL last exactly HTOTAL clk cycles and one frame exactly HTOTAL*VTOTAL cycles.

Reset
REQ-029 While rst=1: hdump=0, vdump=0, LHBL=1, LVBL=1, HS=0, VS=0, frame=0, frame_cnt=0 (if present).
REQ-030 Reset asserted mid-line or mid-frame SHALL force these values immediately, regardless of pxl_cen.
REQ-031 The first pxl_cen cycle after rst falls SHALL produce hdump=1, vdump=0.

Configuration
REQ-032 Macro JTSDRAM_VTIMER_FCNT_EN defined: the module SHALL add output frame_cnt (8 bits) that increments on each frame toggle and wraps 255->0.
REQ-033 Macro JTSDRAM_VTIMER_FCNT_EN undefined: the frame_cnt port and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Default parameters, pxl_cen=1, 384 cycles after reset -> hdump 0..383..0, vdump steps 0->1 exactly at the wrap, LHBL low for hdump 256..383.
REQ-035 pxl_cen asserted one cycle in three -> hdump advances once per three clk cycles, all outputs hold otherwise, one line takes 1152 clk.
REQ-036 Run to vdump=263, hdump=383, then one pxl_cen -> hdump=0, vdump=0, frame toggles, LVBL=1, VS=0.
REQ-037 Sync check over one frame -> HS high for hdump 288..319 (32 pixels/line), VS high for vdump 240..242, LVBL low for vdump 224..263.
REQ-038 rst pulsed at hdump=100, vdump=50, pxl_cen=0 -> outputs return to reset values asynchronously; the next pxl_cen gives hdump=1.
REQ-039 With JTSDRAM_VTIMER_FCNT_EN, run 256 frames -> frame_cnt wraps 255->0, frame returns to 0.

Source files
------------

// File: rtl/jtsdram_vtimer_if.sv
// Video timer bus: pixel clock enable in, raster counters and blanking/sync out.
// Carries frame_cnt only when JTSDRAM_VTIMER_FCNT_EN is defined.
interface jtsdram_vtimer_if;
  logic       pxl_cen;
  logic [8:0] hdump;
  logic [8:0] vdump;
  logic       LHBL;
  logic       LVBL;
  logic       HS;
  logic       VS;
  logic       frame;
`ifdef JTSDRAM_VTIMER_FCNT_EN
  logic [7:0] frame_cnt;
`endif

  modport master (
`ifdef JTSDRAM_VTIMER_FCNT_EN
    output frame_cnt,
`endif
    input  pxl_cen,
    output hdump, vdump, LHBL, LVBL, HS, VS, frame
  );

  modport slave (
`ifdef JTSDRAM_VTIMER_FCNT_EN
    input  frame_cnt,
`endif
    output pxl_cen,
    input  hdump, vdump, LHBL, LVBL, HS, VS, frame
  );
endinterface

// File: rtl/jtsdram_vtimer.sv
// Raster video timer: h/v counters with registered blanking, sync and frame toggle.
// Optional 8-bit frame counter enabled by defining JTSDRAM_VTIMER_FCNT_EN.
module jtsdram_vtimer #(
  parameter int HTOTAL   = 384,
  parameter int HACTIVE  = 256,
  parameter int HS_START = 288,
  parameter int HS_LEN   = 32,
  parameter int VTOTAL   = 264,
  parameter int VACTIVE  = 224,
  parameter int VS_START = 240,
  parameter int VS_LEN   = 3
) (
  input  logic              clk,
  input  logic              rst,
  jtsdram_vtimer_if.master  vt
);
  localparam logic [8:0] H_LAST = 9'(HTOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(VTOTAL - 1);
  // Compares are 10-bit so a window ending exactly at 512 still fits.
  localparam logic [9:0] H_ACT  = 10'(HACTIVE);
  localparam logic [9:0] V_ACT  = 10'(VACTIVE);
  localparam logic [9:0] HS_ON  = 10'(HS_START);
  localparam logic [9:0] HS_OFF = 10'(HS_START + HS_LEN);
  localparam logic [9:0] VS_ON  = 10'(VS_START);
  localparam logic [9:0] VS_OFF = 10'(VS_START + VS_LEN);

  logic [8:0] hdump_q, hdump_d;
  logic [8:0] vdump_q, vdump_d;
  logic       lhbl_q, lhbl_d;
  logic       lvbl_q, lvbl_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       frame_q, frame_d;
  logic       h_wrap, v_wrap;
  logic [9:0] h_ext, v_ext;
`ifdef JTSDRAM_VTIMER_FCNT_EN
  logic [7:0] fcnt_q, fcnt_d;
`endif

  always_comb begin
    h_wrap  = (hdump_q == H_LAST);
    v_wrap  = h_wrap && (vdump_q == V_LAST);
    hdump_d = h_wrap ? 9'd0 : hdump_q + 9'd1;
    vdump_d = vdump_q;
    if (h_wrap) vdump_d = v_wrap ? 9'd0 : vdump_q + 9'd1;
    // Decode from the next counter values so flags line up with hdump/vdump.
    h_ext   = {1'b0, hdump_d};
    v_ext   = {1'b0, vdump_d};
    lhbl_d  = (h_ext < H_ACT);
    lvbl_d  = (v_ext < V_ACT);
    hs_d    = (h_ext >= HS_ON) && (h_ext < HS_OFF);
    vs_d    = (v_ext >= VS_ON) && (v_ext < VS_OFF);
    frame_d = frame_q ^ v_wrap;
`ifdef JTSDRAM_VTIMER_FCNT_EN
    fcnt_d  = fcnt_q + {7'd0, v_wrap};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdump_q <= 9'd0;
      vdump_q <= 9'd0;
      lhbl_q  <= 1'b1;
      lvbl_q  <= 1'b1;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      frame_q <= 1'b0;
`ifdef JTSDRAM_VTIMER_FCNT_EN
      fcnt_q  <= 8'd0;
`endif
    end else if (vt.pxl_cen) begin
      hdump_q <= hdump_d;
      vdump_q <= vdump_d;
      lhbl_q  <= lhbl_d;
      lvbl_q  <= lvbl_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      frame_q <= frame_d;
`ifdef JTSDRAM_VTIMER_FCNT_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  assign vt.hdump = hdump_q;
  assign vt.vdump = vdump_q;
  assign vt.LHBL  = lhbl_q;
  assign vt.LVBL  = lvbl_q;
  assign vt.HS    = hs_q;
  assign vt.VS    = vs_q;
  assign vt.frame = frame_q;
`ifdef JTSDRAM_VTIMER_FCNT_EN
  assign vt.frame_cnt = fcnt_q;
`endif
endmodule

// File: tb/tb_jtsdram_vtimer.sv
// Bench for jtsdram_vtimer: default-size instance plus a small-raster instance
// for frame-level checks; scoreboard model plus directed hand-computed checks.
module tb_jtsdram_vtimer;
  localparam int S_HT = 16, S_HA = 10, S_HSS = 11, S_HSL = 3;
  localparam int S_VT = 12, S_VA = 8,  S_VSS = 9,  S_VSL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;
  int   checks = 0;
  int   failures = 0;

  jtsdram_vtimer_if vd();
  jtsdram_vtimer_if vs();
  assign vd.pxl_cen = cen;
  assign vs.pxl_cen = cen;

  jtsdram_vtimer dut (.clk(clk), .rst(rst), .vt(vd));
  jtsdram_vtimer #(
    .HTOTAL(S_HT), .HACTIVE(S_HA), .HS_START(S_HSS), .HS_LEN(S_HSL),
    .VTOTAL(S_VT), .VACTIVE(S_VA), .VS_START(S_VSS), .VS_LEN(S_VSL)
  ) dut_s (.clk(clk), .rst(rst), .vt(vs));

  always #5 clk = ~clk;

  typedef struct { int h; int v; int fr; int fc; } mstate_t;
  typedef struct packed { logic [30:0] d; logic [30:0] s; } exp_t;
  exp_t q[$];

  logic [30:0] obs_d, obs_s;
  always_comb begin
`ifdef JTSDRAM_VTIMER_FCNT_EN
    obs_d = {vd.frame_cnt, vd.frame, vd.VS, vd.HS, vd.LVBL, vd.LHBL, vd.vdump, vd.hdump};
    obs_s = {vs.frame_cnt, vs.frame, vs.VS, vs.HS, vs.LVBL, vs.LHBL, vs.vdump, vs.hdump};
`else
    obs_d = {8'd0, vd.frame, vd.VS, vd.HS, vd.LVBL, vd.LHBL, vd.vdump, vd.hdump};
    obs_s = {8'd0, vs.frame, vs.VS, vs.HS, vs.LVBL, vs.LHBL, vs.vdump, vs.hdump};
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic mstate_t mstep(mstate_t m, int ht, int vtot);
    mstate_t n = m;
    n.h = (m.h + 1) % ht;
    if (n.h == 0) begin
      n.v = (m.v + 1) % vtot;
      if (n.v == 0) begin
        n.fr = 1 - m.fr;
        n.fc = (m.fc + 1) % 256;
      end
    end
    return n;
  endfunction

  function automatic logic [30:0] mexp(mstate_t m, int ha, int hss, int hsl,
                                       int va, int vss, int vsl);
    logic [7:0] fc;
    fc = 8'd0;
`ifdef JTSDRAM_VTIMER_FCNT_EN
    fc = 8'(m.fc);
`endif
    return {fc, 1'(m.fr), 1'(m.v >= vss && m.v < vss + vsl),
            1'(m.h >= hss && m.h < hss + hsl), 1'(m.v < va), 1'(m.h < ha),
            9'(m.v), 9'(m.h)};
  endfunction

  // Model: advances on each clk edge from the inputs set at the prior negedge.
  initial begin
    mstate_t md, ms;
    md = '{0, 0, 0, 0};
    ms = '{0, 0, 0, 0};
    forever begin
      @(posedge clk);
      if (rst) begin
        md = '{0, 0, 0, 0};
        ms = '{0, 0, 0, 0};
      end else if (cen) begin
        md = mstep(md, 384, 264);
        ms = mstep(ms, S_HT, S_VT);
      end
      q.push_back('{d: mexp(md, 256, 288, 32, 224, 240, 3),
                    s: mexp(ms, S_HA, S_HSS, S_HSL, S_VA, S_VSS, S_VSL)});
    end
  end

  // Monitor: outputs are registered, so they are presented after every clk edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sb_default", {1'b0, obs_d}, {1'b0, e.d});
        chk("sb_small",   {1'b0, obs_s}, {1'b0, e.s});
      end
    end
  end

  initial begin
    int lhbl_lo, hs_hi, vs_hi, lvbl_lo, chg, fr_chg, found;
    logic [8:0] prev;
    logic       fr;

    cen = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hdump", 32'(vd.hdump), 32'd0);
    chk("rst_vdump", 32'(vd.vdump), 32'd0);
    chk("rst_flags", {28'd0, vd.LHBL, vd.LVBL, vd.HS, vd.VS}, 32'b1100);
    chk("rst_frame", 32'(vd.frame), 32'd0);

    // One full default line with cen always on.
    rst = 1'b0;
    cen = 1'b1;
    lhbl_lo = 0;
    hs_hi = 0;
    for (int i = 1; i <= 384; i++) begin
      @(negedge clk);
      if (!vd.LHBL) lhbl_lo++;
      if (vd.HS) hs_hi++;
      if (i == 1) begin
        chk("first_hdump", 32'(vd.hdump), 32'd1);
        chk("first_vdump", 32'(vd.vdump), 32'd0);
      end
      if (i == 383) begin
        chk("pre_wrap_h", 32'(vd.hdump), 32'd383);
        chk("pre_wrap_v", 32'(vd.vdump), 32'd0);
      end
    end
    chk("wrap_h", 32'(vd.hdump), 32'd0);
    chk("wrap_v", 32'(vd.vdump), 32'd1);
    chk("lhbl_low_cnt", 32'(lhbl_lo), 32'd128);
    chk("hs_high_cnt", 32'(hs_hi), 32'd32);

    // cen one cycle in three: a line takes 1152 clocks.
    prev = vd.hdump;
    chg = 0;
    for (int i = 0; i < 1152; i++) begin
      cen = (i % 3 == 0);
      @(negedge clk);
      if (vd.hdump != prev) chg++;
      prev = vd.hdump;
    end
    chk("slow_changes", 32'(chg), 32'd384);
    chk("slow_h", 32'(vd.hdump), 32'd0);
    chk("slow_v", 32'(vd.vdump), 32'd2);

    // Simultaneous h/v wrap on the small raster.
    cen = 1'b1;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (vs.hdump == 9'(S_HT - 1) && vs.vdump == 9'(S_VT - 1)) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_last_pixel", 32'(found), 32'd1);
    fr = vs.frame;
    @(negedge clk);
    chk("fw_h", 32'(vs.hdump), 32'd0);
    chk("fw_v", 32'(vs.vdump), 32'd0);
    chk("fw_frame_toggle", 32'(vs.frame ^ fr), 32'd1);
    chk("fw_lvbl_vs", {30'd0, vs.LVBL, vs.VS}, 32'b10);

    // Sync/blanking populations over one small frame.
    hs_hi = 0; vs_hi = 0; lvbl_lo = 0; lhbl_lo = 0; fr_chg = 0;
    fr = vs.frame;
    for (int i = 0; i < S_HT * S_VT; i++) begin
      @(negedge clk);
      if (vs.HS) hs_hi++;
      if (vs.VS) vs_hi++;
      if (!vs.LVBL) lvbl_lo++;
      if (!vs.LHBL) lhbl_lo++;
      if (vs.frame != fr) fr_chg++;
      fr = vs.frame;
    end
    chk("s_hs_cnt", 32'(hs_hi), 32'd36);
    chk("s_vs_cnt", 32'(vs_hi), 32'd32);
    chk("s_lvbl_lo", 32'(lvbl_lo), 32'd64);
    chk("s_lhbl_lo", 32'(lhbl_lo), 32'd72);
    chk("s_frame_toggles", 32'(fr_chg), 32'd1);

    // Async reset mid-frame with cen low.
    found = 0;
    for (int i = 0; i < 20000; i++) begin
      if (vd.hdump == 9'd100 && vd.vdump == 9'd50) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_100_50", 32'(found), 32'd1);
    cen = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_h", 32'(vd.hdump), 32'd0);
    chk("arst_v", 32'(vd.vdump), 32'd0);
    chk("arst_flags", {28'd0, vd.LHBL, vd.LVBL, vd.HS, vd.VS}, 32'b1100);
    chk("arst_s_h", 32'(vs.hdump), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("hold_after_rst", 32'(vd.hdump), 32'd0);
    cen = 1'b1;
    @(negedge clk);
    chk("post_rst_h", 32'(vd.hdump), 32'd1);
    chk("post_rst_v", 32'(vd.vdump), 32'd0);

`ifdef JTSDRAM_VTIMER_FCNT_EN
    // 256 small frames from reset; one cen cycle already elapsed.
    repeat (255 * S_HT * S_VT - 1) @(negedge clk);
    chk("fcnt_255", 32'(vs.frame_cnt), 32'd255);
    chk("frame_at_255", 32'(vs.frame), 32'd1);
    repeat (S_HT * S_VT) @(negedge clk);
    chk("fcnt_wrap", 32'(vs.frame_cnt), 32'd0);
    chk("frame_back", 32'(vs.frame), 32'd0);
    chk("fcnt_default", 32'(vd.frame_cnt), 32'd0);
`endif

    cen = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
